// File: rtl/pipe_buf_pkg.sv
// pipe_buf_pkg: shared state encoding and default bubble payload for pipeline buffer stages.
package pipe_buf_pkg;
    typedef enum logic [1:0] {PB_EMPTY = 2'd0, PB_ONE = 2'd1, PB_TWO = 2'd2} pb_state_e;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: reusable valid/ready pipeline register with flush, bubble output,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_buf
    import pipe_buf_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter bit               SKID         = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(RV_NOP),
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);
    pb_state_e        state;
    logic [WIDTH-1:0] main_q;
    logic             accept, issue;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;

    always_comb begin
        out_valid = state != PB_EMPTY;
        out_data  = out_valid ? main_q : BUBBLE_VALUE;
        occupancy = state;
    end

    generate
        if (SKID) begin : g_skid
            pb_state_e        state_nx;
            logic [WIDTH-1:0] skid_q;
            always_ff @(posedge clk) begin
                if (!rst_n) state <= PB_EMPTY;
                else state <= state_nx;
            end
            always_comb begin
                state_nx = state;
                if (flush) state_nx = PB_EMPTY;
                else
                    case (state)
                        PB_EMPTY: state_nx = accept ? PB_ONE : PB_EMPTY;
                        PB_ONE:   state_nx = (accept && !issue) ? PB_TWO :
                                             (issue && !accept) ? PB_EMPTY : PB_ONE;
                        PB_TWO:   state_nx = issue ? PB_ONE : PB_TWO;
                        default:  state_nx = PB_EMPTY;
                    endcase
            end
            // in_ready comes straight off the state flop, so upstream never sees a comb path
            always_ff @(posedge clk) begin
                if (state == PB_TWO) begin
                    if (issue) main_q <= skid_q;
                end else if (accept) begin
                    if (state == PB_EMPTY || issue) main_q <= in_data;
                    else skid_q <= in_data;
                end
            end
            assign in_ready = rst_n & (state != PB_TWO);
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst_n) state <= PB_EMPTY;
                else if (flush) state <= PB_EMPTY;
                else if (accept) state <= PB_ONE;
                else if (issue) state <= PB_EMPTY;
            end
            always_ff @(posedge clk) begin
                if (accept) main_q <= in_data;
            end
            assign in_ready = rst_n & (!out_valid | out_ready);
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out_valid & ~out_ready),
        .clr  (stall_clr),
        .cnt  (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: table-driven checks of the skid variant plus hand sequences for SKID=0 and counter saturation.
module tb_pipe_stage_buf;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush, stall_clr;
    logic [31:0] in_data;
    logic        ir, ov, ir0, ov0, ir4, ov4;
    logic [31:0] od, od0, od4;
    logic [1:0]  occ, occ0, occ4;
    logic [15:0] st, st0;
    logic [3:0]  st4;
    int          total = 0, passed = 0;

    typedef struct {
        logic        rst_n, iv;
        logic [31:0] d;
        logic        ordy, fl, clr, ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
        logic [15:0] st;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.SKID(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir), .in_data(in_data),
        .flush(flush), .out_valid(ov), .out_ready(out_ready), .out_data(od),
        .occupancy(occ), .stall_cnt(st), .stall_clr(stall_clr));
    pipe_stage_buf #(.SKID(1'b0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(occ0), .stall_cnt(st0), .stall_clr(stall_clr));
    pipe_stage_buf #(.SKID(1'b1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .flush(flush), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .occupancy(occ4), .stall_cnt(st4), .stall_clr(stall_clr));

    function automatic vec_t v(logic r, logic i, logic [31:0] d, logic o, logic f, logic c,
                               logic eov, logic [31:0] eod, logic [1:0] eocc, logic eir, logic [15:0] est);
        vec_t t;
        t.rst_n = r; t.iv = i; t.d = d; t.ordy = o; t.fl = f; t.clr = c;
        t.ov = eov; t.od = eod; t.occ = eocc; t.ir = eir; t.st = est;
        return t;
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", n, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held two cycles with traffic present
        tbl.push_back(v(0, 1, 'haa, 0, 0, 0, 0, 'h13, 0, 0, 0));
        tbl.push_back(v(0, 1, 'hbb, 0, 0, 0, 0, 'h13, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 'h13, 0, 1, 0));
        // streaming 1..8
        tbl.push_back(v(1, 1, 1, 1, 0, 0, 0, 'h13, 0, 1, 0));
        for (int i = 2; i <= 8; i++) tbl.push_back(v(1, 1, i, 1, 0, 0, 1, i - 1, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 8, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 'h13, 0, 1, 0));
        // backpressure: A,B held, C refused
        tbl.push_back(v(1, 1, 'ha, 0, 0, 0, 0, 'h13, 0, 1, 0));
        tbl.push_back(v(1, 1, 'hb, 0, 0, 0, 1, 'ha, 1, 1, 0));
        tbl.push_back(v(1, 1, 'hc, 0, 0, 0, 1, 'ha, 2, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 'ha, 2, 0, 2));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 'ha, 2, 0, 3));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 'hb, 1, 1, 3));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 'h13, 0, 1, 3));
        // flush while TWO with input offered, then flush in ONE with a real accept
        tbl.push_back(v(1, 1, 'hd, 0, 0, 0, 0, 'h13, 0, 1, 3));
        tbl.push_back(v(1, 1, 'he, 0, 0, 0, 1, 'hd, 1, 1, 3));
        tbl.push_back(v(1, 1, 'hf, 0, 1, 0, 1, 'hd, 2, 0, 4));
        tbl.push_back(v(1, 1, 'h11, 0, 0, 0, 0, 'h13, 0, 1, 5));
        tbl.push_back(v(1, 1, 'h22, 0, 1, 0, 1, 'h11, 1, 1, 5));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 'h13, 0, 1, 6));
        tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 'h13, 0, 1, 6));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 'h13, 0, 1, 0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; in_valid = tbl[i].iv; in_data = tbl[i].d;
            out_ready = tbl[i].ordy; flush = tbl[i].fl; stall_clr = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d.out_valid", i), 32'(ov), 32'(tbl[i].ov));
            chk($sformatf("v%0d.out_data", i), od, tbl[i].od);
            chk($sformatf("v%0d.occupancy", i), 32'(occ), 32'(tbl[i].occ));
            chk($sformatf("v%0d.in_ready", i), 32'(ir), 32'(tbl[i].ir));
            chk($sformatf("v%0d.stall_cnt", i), 32'(st), 32'(tbl[i].st));
            tick();
        end

        // SKID=0: combinational in_ready, simultaneous issue/accept, flush
        rst_n = 0; in_valid = 0; out_ready = 0; flush = 0; stall_clr = 0; in_data = 0;
        tick();
        rst_n = 1; in_valid = 1; in_data = 'h55;
        @(negedge clk);
        chk("s0.empty_in_ready", 32'(ir0), 1);
        chk("s0.empty_out_valid", 32'(ov0), 0);
        tick();
        in_data = 'h66;
        @(negedge clk);
        chk("s0.stall_in_ready", 32'(ir0), 0);
        chk("s0.held_data", od0, 'h55);
        chk("s0.held_occ", 32'(occ0), 1);
        tick();
        out_ready = 1;
        @(negedge clk);
        chk("s0.ready_in_ready", 32'(ir0), 1);
        chk("s0.ready_data", od0, 'h55);
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("s0.swap_valid", 32'(ov0), 1);
        chk("s0.swap_data", od0, 'h66);
        chk("s0.swap_occ", 32'(occ0), 1);
        tick();
        in_valid = 1; in_data = 'h77; flush = 1;
        @(negedge clk);
        chk("s0.drain_occ", 32'(occ0), 0);
        tick();
        in_valid = 0; flush = 0;
        @(negedge clk);
        chk("s0.flush_valid", 32'(ov0), 0);
        chk("s0.flush_data", od0, 'h13);
        chk("s0.flush_occ", 32'(occ0), 0);
        tick();

        // stall counter saturation and clear
        rst_n = 0; out_ready = 0;
        tick();
        rst_n = 1; in_valid = 1; in_data = 'h9;
        tick();
        in_valid = 0;
        repeat (20) tick();
        @(negedge clk);
        chk("c4.saturated", 32'(st4), 15);
        chk("c16.count20", 32'(st), 20);
        stall_clr = 1;
        tick();
        stall_clr = 0;
        @(negedge clk);
        chk("c4.cleared", 32'(st4), 0);
        tick();
        @(negedge clk);
        chk("c4.restart", 32'(st4), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Generic, parametrised pipeline buffer stage that replaces fixed per-stage struct registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries an opaque packed payload of WIDTH bits with valid/ready handshake, synchronous flush and bubble (NOP) insertion.
- Optional 2-entry skid mode registers the upstream ready.
- Saturating stall-cycle counter for performance monitoring.
- One instance sits between each pair of core pipeline stages; the payload is a stage struct cast to bits.

Parameters:
WIDTH, 32, payload width in bits (≥1)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
BUBBLE_VALUE, 32'h0000_0013 zero-extended/truncated to WIDTH, value driven on out_data when out_valid=0 and loaded on flush
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  upstream payload valid
in_ready  out  1  stage accepts payload this cycle
in_data  in  WIDTH  upstream payload
flush  in  1  synchronous discard of all held and incoming payloads
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts payload
out_data  out  WIDTH  head payload; BUBBLE_VALUE when out_valid=0
occupancy  out  2  entries held (0..2; max 1 when SKID=0)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Transfers: accept = in_valid & in_ready; issue = out_valid & out_ready.
- Reset (rst_n=0 at edge):
  - State EMPTY; out_valid=0; out_data=BUBBLE_VALUE; occupancy=0; stall_cnt=0.
  - in_ready=1 from the first cycle after reset is released; in_ready=0 while rst_n=0.
  - Reset overrides flush and all transfers, including mid-operation with entries held.
- Priority per edge: reset > flush > normal transfer.
- Flush:
  - All entries are discarded and the state goes to EMPTY; an accept on the same cycle is discarded.
  - out_data reads BUBBLE_VALUE the next cycle; issue on the flush cycle is still honoured (downstream saw it).
  - stall_cnt is unaffected.
- SKID=1, states EMPTY / ONE (main only) / TWO (main+skid); in_ready = (state != TWO), registered.
  - EMPTY: accept → ONE (main = in_data).
  - ONE: accept & !issue → TWO (skid = in_data); issue & !accept → EMPTY; accept & issue → ONE (main = in_data).
  - TWO: issue → ONE (main ← skid). accept cannot occur.
  - out_valid = (state != EMPTY); out_data = main.
  - Latency 1 cycle in to out; full throughput with out_ready=1.
  - Order is strictly FIFO.
- SKID=0: in_ready = !out_valid | out_ready, combinational. A register loads on accept and clears valid on issue without accept. Latency 1, full throughput.
- occupancy mirrors state: EMPTY=0, ONE=1, TWO=2.
- stall_cnt:
  - Increments when out_valid & !out_ready, saturating at all-ones.
  - stall_clr has priority over increment and forces 0.
- in_data is ignored when in_valid=0.
- out_data does not change while out_valid=1 and out_ready=0.

Decomposition:
- Shared package pipe_buf_pkg: typedef enum logic [1:0] {PB_EMPTY, PB_ONE, PB_TWO}; localparam RV_NOP = 32'h0000_0013.
- Existing stage structs stay in their package; callers cast struct ↔ logic [WIDTH-1:0].
- One natural sub-module: sat_counter (CNT_W, inc, clr) for stall_cnt.
- SKID variants are handled by a generate branch inside pipe_stage_buf, not separate modules.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, out_data=0x13, occupancy=0, in_ready=0 during reset and 1 on the cycle after release.
2. Streaming, SKID=1, out_ready=1: in_data 1..8 on consecutive cycles → out_data 1..8 one cycle later, no gaps, occupancy stays 1.
3. Backpressure, SKID=1: send A,B with out_ready=0 → occupancy=2, in_ready=0, out_data=A held, stall_cnt increments each cycle. Then out_ready=1 → A, B in order, in_ready returns to 1 one cycle after first issue.
4. Flush while TWO with in_valid=1 on the same cycle → next cycle occupancy=0, out_valid=0, out_data=0x13; the flushed input never appears.
5. SKID=0, out_valid=1, out_ready=0 → in_ready=0 in the same cycle; out_ready=1 with in_valid=1 → simultaneous issue and accept, occupancy stays 1.
6. CNT_W=4 stalled for 20 cycles → stall_cnt saturates at 15. stall_clr=1 together with a stall → stall_cnt=0 next cycle.
